// File: rtl/hdmi_rx_pkg.sv
// Shared constants and types for the TMDS receive channel: control tokens,
// the TERC4 code table and the alignment FSM states.
package hdmi_rx_pkg;

   localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

   // TERC4 codes, indexed by the nibble they carry.
   localparam logic [9:0] TERC4_TABLE [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };

   typedef enum logic {SEARCH, LOCKED} state_t;

   // Bit slip offsets cycle through 0..9.
   function automatic logic [3:0] next_offset(input logic [3:0] off);
      return (off == 4'd9) ? 4'd0 : off + 4'd1;
   endfunction

endpackage

// File: rtl/tmds_symbol_decoder.sv
// Combinational decode of one aligned 10-bit TMDS symbol into video data,
// control code and TERC4 nibble, with match flags for the latter two.
module tmds_symbol_decoder
   import hdmi_rx_pkg::*;
(
   input  logic [9:0] sym,
   output logic [7:0] data,
   output logic       ctrl_match,
   output logic [1:0] ctrl,
   output logic       terc4_match,
   output logic [3:0] terc4
);

   logic [7:0] d;

   // Undo the optional inversion, then the XOR/XNOR transition chain.
   always_comb begin
      d       = sym[9] ? ~sym[7:0] : sym[7:0];
      data    = '0;
      data[0] = d[0];
      for (int i = 1; i < 8; i++)
         data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
   end

   // Control token lookup.
   always_comb begin
      ctrl_match = 1'b1;
      ctrl       = 2'b00;
      case (sym)
         CTRL_TOK_00: ctrl = 2'b00;
         CTRL_TOK_01: ctrl = 2'b01;
         CTRL_TOK_10: ctrl = 2'b10;
         CTRL_TOK_11: ctrl = 2'b11;
         default:     ctrl_match = 1'b0;
      endcase
   end

   // TERC4 table search; codes are unique so at most one entry matches.
   always_comb begin
      terc4_match = 1'b0;
      terc4       = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (sym == TERC4_TABLE[i]) begin
            terc4_match = 1'b1;
            terc4       = 4'(i);
         end
      end
   end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: 20-bit sliding window over the deserializer
// output, bit-slip search for symbol alignment using control-token runs,
// lock supervision, and registered decode outputs.
module tmds_channel_decoder
   import hdmi_rx_pkg::*;
#(
   parameter int LOCK_RUN   = 8,
   parameter int DWELL      = 1024,
   parameter int LOSS_LIMIT = 4
) (
   input  logic       clk_pixel,
   input  logic       reset_n,
   input  logic [9:0] tmds_word,
   output logic       locked,
   output logic [3:0] bit_offset,
   output logic       data_valid,
   output logic [7:0] data,
   output logic       ctrl_valid,
   output logic [1:0] ctrl,
   output logic       terc4_valid,
   output logic [3:0] terc4
);

   localparam int RUN_W  = $clog2(LOCK_RUN + 1);
   localparam int DW_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int MISS_W = $clog2(LOSS_LIMIT + 1);
   localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_RUN);
   localparam logic [DW_W-1:0]   DW_LAST  = DW_W'(DWELL - 1);
   localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(LOSS_LIMIT);

   logic [9:0]        w_new, w_old;
   logic [19:0]       window;
   logic [4:0]        sel;
   logic [9:0]        sym;
   logic [7:0]        dec_data;
   logic              dec_ctrl_match, dec_terc4_match;
   logic [1:0]        dec_ctrl;
   logic [3:0]        dec_terc4;

   state_t            state, state_n;
   logic [3:0]        off_n;
   logic [RUN_W-1:0]  run_cnt, run_n;
   logic [DW_W-1:0]   dwell_cnt, dwell_n;
   logic [MISS_W-1:0] miss_cnt, miss_n;
   logic              hit, hit_n;
   logic              run_full, wrap;

   // Two-word history so any 10-bit alignment is visible in one window.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         w_new <= '0;
         w_old <= '0;
      end else begin
         w_new <= tmds_word;
         w_old <= w_new;
      end
   end

   assign window = {w_new, w_old};
   assign sel    = {1'b0, bit_offset};
   assign sym    = window[sel +: 10];

   tmds_symbol_decoder u_dec (
      .sym         (sym),
      .data        (dec_data),
      .ctrl_match  (dec_ctrl_match),
      .ctrl        (dec_ctrl),
      .terc4_match (dec_terc4_match),
      .terc4       (dec_terc4)
   );

   assign run_full = (run_cnt == RUN_MAX);
   assign wrap     = (dwell_cnt == DW_LAST);
   assign locked   = (state == LOCKED);

   // State, slip offset and alignment counters.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         state      <= SEARCH;
         bit_offset <= '0;
         run_cnt    <= '0;
         dwell_cnt  <= '0;
         miss_cnt   <= '0;
         hit        <= 1'b0;
      end else begin
         state      <= state_n;
         bit_offset <= off_n;
         run_cnt    <= run_n;
         dwell_cnt  <= dwell_n;
         miss_cnt   <= miss_n;
         hit        <= hit_n;
      end
   end

   // Next-state logic. A completed run takes priority over a dwell wrap in
   // SEARCH; in LOCKED a run completed on the wrap cycle still counts as a hit.
   always_comb begin
      state_n = state;
      off_n   = bit_offset;
      miss_n  = miss_cnt;
      run_n   = dec_ctrl_match ? (run_full ? run_cnt : run_cnt + 1'b1) : '0;
      dwell_n = wrap ? '0 : dwell_cnt + 1'b1;
      hit_n   = wrap ? 1'b0 : (hit | run_full);
      case (state)
         SEARCH: begin
            if (run_full) begin
               state_n = LOCKED;
               dwell_n = '0;
               miss_n  = '0;
               hit_n   = 1'b0;
            end else if (wrap) begin
               off_n = next_offset(bit_offset);
               run_n = '0;
            end
         end
         LOCKED: begin
            if (wrap) begin
               if (hit | run_full) begin
                  miss_n = '0;
               end else if (miss_cnt + 1'b1 == MISS_MAX) begin
                  state_n = SEARCH;
                  off_n   = next_offset(bit_offset);
                  run_n   = '0;
                  dwell_n = '0;
                  miss_n  = '0;
                  hit_n   = 1'b0;
               end else begin
                  miss_n = miss_cnt + 1'b1;
               end
            end
         end
         default: state_n = SEARCH;
      endcase
   end

   // Registered decode results; valids are qualified by the current lock.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         data        <= '0;
         ctrl        <= '0;
         terc4       <= '0;
         data_valid  <= 1'b0;
         ctrl_valid  <= 1'b0;
         terc4_valid <= 1'b0;
      end else begin
         data        <= dec_data;
         ctrl        <= dec_ctrl;
         terc4       <= dec_terc4;
         data_valid  <= locked & ~dec_ctrl_match;
         ctrl_valid  <= locked & dec_ctrl_match;
         terc4_valid <= locked & dec_terc4_match;
      end
   end

endmodule
